// File: rtl/avalon_st_if.sv
// rtl/avalon_st_if.sv - Avalon-ST packet stream bundle with master/slave views
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 4
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_downsizer.sv
// rtl/avalon_st_downsizer.sv - wide-to-narrow Avalon-ST width adapter with sop/eop/empty rework
module avalon_st_downsizer #(
  parameter int IN_BYTES  = 16,
  parameter int OUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  in_stream,
  avalon_st_if.master out_stream
);

  // Counter width that never collapses to zero bits, even for a 1:1 ratio.
  function automatic int log2up_func(input int value);
    return (value > 2) ? $clog2(value) : 1;
  endfunction

  localparam int RATIO  = IN_BYTES / OUT_BYTES;
  localparam int IDX_W  = log2up_func(RATIO);
  localparam int IN_W   = 8 * IN_BYTES;
  localparam int OUT_W  = 8 * OUT_BYTES;
  localparam int OUT_EW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  generate
    if ((OUT_BYTES > IN_BYTES) || ((IN_BYTES % OUT_BYTES) != 0)) begin : g_bad_widths
      $error("avalon_st_downsizer: IN_BYTES must be a multiple of OUT_BYTES");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state;
  logic [IN_W-1:0]     hold_data;
  logic                hold_sop;
  logic                hold_eop;
  logic [IDX_W-1:0]    last_idx;
  logic [IDX_W-1:0]    chunk_idx;
  logic [OUT_EW-1:0]   hold_empty;

  logic                hold_valid;
  logic                on_last;
  logic                in_fire;
  logic                out_fire;
  logic [IDX_W-1:0]    load_last;
  logic [OUT_EW-1:0]   load_empty;
  logic [OUT_W-1:0]    chunk_data;

  assign hold_valid = (state == SEND);
  assign on_last    = (chunk_idx == last_idx);

  // The wide side may only advance once the final chunk of the held beat is leaving.
  assign in_stream.rdy = !hold_valid || (out_stream.rdy && on_last);
  assign in_fire       = in_stream.valid && in_stream.rdy;
  assign out_fire      = hold_valid && out_stream.rdy;

  // Size an incoming beat: how many chunks carry real bytes, and the pad left in the final one.
  always_comb begin
    int valid_bytes;
    int chunks;
    valid_bytes = IN_BYTES;
    chunks      = RATIO;
    load_last   = IDX_W'(RATIO - 1);
    load_empty  = '0;
    if (in_stream.eop) begin
      valid_bytes = IN_BYTES - int'(in_stream.empty);
      if (valid_bytes < 1) begin
        valid_bytes = 1;
      end
      chunks     = (valid_bytes + OUT_BYTES - 1) / OUT_BYTES;
      load_last  = IDX_W'(chunks - 1);
      load_empty = OUT_EW'(chunks * OUT_BYTES - valid_bytes);
    end
  end

  // Select the current chunk; chunk 0 is the most significant slice of the held beat.
  always_comb begin
    chunk_data = '0;
    for (int c = 0; c < RATIO; c++) begin
      if (chunk_idx == IDX_W'(c)) begin
        chunk_data = hold_data[(RATIO-1-c)*OUT_W +: OUT_W];
      end
    end
  end

  assign out_stream.valid = hold_valid;
  assign out_stream.data  = chunk_data;
  assign out_stream.sop   = hold_valid && hold_sop && (chunk_idx == '0);
  assign out_stream.eop   = hold_valid && hold_eop && on_last;
  assign out_stream.empty = out_stream.eop ? hold_empty : '0;

  // Holding-register FSM: load a beat, walk its chunks, reload or go idle on the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_data  <= '0;
      hold_sop   <= 1'b0;
      hold_eop   <= 1'b0;
      last_idx   <= '0;
      hold_empty <= '0;
      chunk_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            state      <= SEND;
            hold_data  <= in_stream.data;
            hold_sop   <= in_stream.sop;
            hold_eop   <= in_stream.eop;
            last_idx   <= load_last;
            hold_empty <= load_empty;
            chunk_idx  <= '0;
          end
        end
        SEND: begin
          if (in_fire) begin
            hold_data  <= in_stream.data;
            hold_sop   <= in_stream.sop;
            hold_eop   <= in_stream.eop;
            last_idx   <= load_last;
            hold_empty <= load_empty;
            chunk_idx  <= '0;
          end else if (out_fire) begin
            if (on_last) begin
              state <= IDLE;
            end else begin
              chunk_idx <= chunk_idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_st_downsizer.sv
// tb/tb_avalon_st_downsizer.sv - randomized and directed bench for avalon_st_downsizer
module tb_avalon_st_downsizer;

  localparam int IN_BYTES  = 16;
  localparam int OUT_BYTES = 4;
  localparam int B_BYTES   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(IN_BYTES))  in_a ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(OUT_BYTES)) out_a ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(B_BYTES))   in_b ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(B_BYTES))   out_b ();

  avalon_st_downsizer #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES)) dut_a (
    .clk(clk), .rst(rst), .in_stream(in_a), .out_stream(out_a)
  );

  avalon_st_downsizer #(.IN_BYTES(B_BYTES), .OUT_BYTES(B_BYTES)) dut_b (
    .clk(clk), .rst(rst), .in_stream(in_b), .out_stream(out_b)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic rnd_rdy = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } chunk_t;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        in_rdy;
    int          cyc;
  } obs_t;

  chunk_t     exp_q[$];
  obs_t       log_q[$];
  logic [7:0] in_bytes[$];
  logic [7:0] out_bytes[$];
  int         accept_cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Reference: an accepted wide beat becomes the list of narrow beats it must produce.
  task automatic model_accept(input logic [127:0] d, input logic s, input logic e, input logic [3:0] em);
    int v;
    int n;
    chunk_t c;
    v = e ? IN_BYTES - int'(em) : IN_BYTES;
    n = (v + OUT_BYTES - 1) / OUT_BYTES;
    for (int k = 0; k < n; k++) begin
      c.data  = d[127 - 32*k -: 32];
      c.sop   = s && (k == 0);
      c.eop   = e && (k == n - 1);
      c.empty = (e && (k == n - 1)) ? 2'(n * OUT_BYTES - v) : 2'd0;
      exp_q.push_back(c);
    end
    for (int b = 0; b < v; b++) begin
      in_bytes.push_back(d[127 - 8*b -: 8]);
    end
  endtask

  // Per-cycle compare for the 16->4 instance, sampled on the falling edge.
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic        prev_sop, prev_eop;
  logic [1:0]  prev_empty;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
      check("rst_out_valid", out_a.valid, 1'b0);
      check("rst_in_rdy", in_a.rdy, 1'b1);
    end else begin
      obs_t o;
      int nb;
      check("out_valid", out_a.valid, exp_q.size() != 0);
      check("in_rdy", in_a.rdy, (exp_q.size() == 0) || (out_a.rdy && exp_q.size() == 1));
      if (out_a.valid && exp_q.size() != 0) begin
        check("out_data", out_a.data, exp_q[0].data);
        check("out_sop", out_a.sop, exp_q[0].sop);
        check("out_eop", out_a.eop, exp_q[0].eop);
        check("out_empty", out_a.empty, exp_q[0].empty);
      end
      if (stall_prev) begin
        check("stall_stable", {out_a.data, out_a.sop, out_a.eop, out_a.empty},
              {prev_data, prev_sop, prev_eop, prev_empty});
      end
      stall_prev = out_a.valid && !out_a.rdy;
      prev_data  = out_a.data;
      prev_sop   = out_a.sop;
      prev_eop   = out_a.eop;
      prev_empty = out_a.empty;
      if (out_a.valid && out_a.rdy) begin
        o.data = out_a.data; o.sop = out_a.sop; o.eop = out_a.eop;
        o.empty = out_a.empty; o.in_rdy = in_a.rdy; o.cyc = cycle;
        log_q.push_back(o);
        nb = out_a.eop ? OUT_BYTES - int'(out_a.empty) : OUT_BYTES;
        for (int b = 0; b < nb; b++) out_bytes.push_back(out_a.data[31 - 8*b -: 8]);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_a.valid && in_a.rdy) begin
        model_accept(in_a.data, in_a.sop, in_a.eop, in_a.empty);
        accept_cyc = cycle;
      end
    end
  end

  // Per-cycle compare for the 1:1 instance: a beat accepted now must appear, unchanged but
  // with empty cleared on non-eop beats, in the very next cycle.
  logic        eb_pend = 1'b0;
  logic [63:0] eb_data;
  logic        eb_sop, eb_eop;
  logic [2:0]  eb_empty;

  always @(negedge clk) begin
    if (!rst) begin
      eb_pend = 1'b0;
    end else begin
      check("b_out_valid", out_b.valid, eb_pend);
      check("b_in_rdy", in_b.rdy, 1'b1);
      if (eb_pend) begin
        check("b_out_beat", {out_b.data, out_b.sop, out_b.eop, out_b.empty},
              {eb_data, eb_sop, eb_eop, eb_empty});
      end
      eb_pend  = in_b.valid && in_b.rdy;
      eb_data  = in_b.data;
      eb_sop   = in_b.sop;
      eb_eop   = in_b.eop;
      eb_empty = in_b.eop ? in_b.empty : 3'd0;
    end
  end

  // Output back-pressure for the narrow side.
  initial begin
    out_a.rdy = 1'b1;
    out_b.rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_a.rdy = rnd_rdy ? (($urandom % 2) == 0) : 1'b1;
    end
  end

  task automatic send_a(input logic [127:0] d, input logic s, input logic e, input logic [3:0] em);
    logic fired;
    in_a.data = d; in_a.sop = s; in_a.eop = e; in_a.empty = em; in_a.valid = 1'b1;
    fired = 1'b0;
    for (int t = 0; t < 200 && !fired; t++) begin
      @(negedge clk);
      fired = in_a.rdy;
      @(posedge clk);
      #1;
    end
    check("send_a_accepted", fired, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] d,
                            input logic s, input logic e, input logic [1:0] em);
    check(name, {log_q[idx].data, log_q[idx].sop, log_q[idx].eop, log_q[idx].empty}, {d, s, e, em});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    int          vcount;
    int          rcount;
    int          mism;
    int          len;
    logic        e;
    logic [127:0] d;

    rst = 1'b0;
    in_a.valid = 1'b0; in_a.data = '0; in_a.sop = 1'b0; in_a.eop = 1'b0; in_a.empty = '0;
    in_b.valid = 1'b0; in_b.data = '0; in_b.sop = 1'b0; in_b.eop = 1'b0; in_b.empty = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {out_a.valid, out_a.sop, out_a.eop, out_a.empty, out_a.data},
          {1'b0, 1'b0, 1'b0, 2'd0, 32'd0});
    check("reset_in_rdy", in_a.rdy, 1'b1);
    check("reset_b_valid", out_b.valid, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    idle_cycles(2);

    // Single-beat packet split into four words.
    log_q.delete();
    send_a(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 1'b1, 4'd0);
    in_a.valid = 1'b0;
    idle_cycles(6);
    check("single_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check_word("single_w0", 0, 32'h00112233, 1'b1, 1'b0, 2'd0);
      check_word("single_w1", 1, 32'h44556677, 1'b0, 1'b0, 2'd0);
      check_word("single_w2", 2, 32'h8899AABB, 1'b0, 1'b0, 2'd0);
      check_word("single_w3", 3, 32'hCCDDEEFF, 1'b0, 1'b1, 2'd0);
      check("single_latency", log_q[0].cyc, accept_cyc + 1);
    end

    // eop with empty=9: seven valid bytes, two words, trailing chunks skipped.
    log_q.delete();
    send_a(128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF, 1'b1, 1'b1, 4'd9);
    in_a.valid = 1'b0;
    idle_cycles(6);
    check("short_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check_word("short_w0", 0, 32'hA0A1A2A3, 1'b1, 1'b0, 2'd0);
      check_word("short_w1", 1, 32'hA4A5A6A7, 1'b0, 1'b1, 2'd1);
      check("short_rdy_w0", log_q[0].in_rdy, 1'b0);
      check("short_rdy_w1", log_q[1].in_rdy, 1'b1);
    end

    // Three beats back-to-back: twelve contiguous words, in.rdy once every four cycles.
    log_q.delete();
    fork
      begin
        send_a({4{32'h11111111}}, 1'b1, 1'b0, 4'd0);
        send_a({4{32'h22222222}}, 1'b0, 1'b0, 4'd0);
        send_a({4{32'h33333333}}, 1'b0, 1'b1, 4'd0);
        in_a.valid = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
          @(negedge clk);
          seen = out_a.valid;
        end
        check("b2b_start", seen, 1'b1);
        vcount = int'(seen);
        rcount = int'(seen && in_a.rdy);
        for (int k = 1; k < 12; k++) begin
          @(negedge clk);
          vcount += int'(out_a.valid);
          rcount += int'(in_a.rdy);
        end
      end
    join
    idle_cycles(4);
    check("b2b_valid_cycles", vcount, 12);
    check("b2b_rdy_pulses", rcount, 3);
    check("b2b_count", log_q.size(), 12);
    if (log_q.size() == 12) begin
      check("b2b_contiguous", log_q[11].cyc - log_q[0].cyc, 11);
    end

    // Random packets under random back-pressure; byte stream must survive intact.
    in_bytes.delete();
    out_bytes.delete();
    rnd_rdy = 1'b1;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_a.valid = 1'b0;
          idle_cycles($urandom_range(1, 2));
        end
        d = {$urandom, $urandom, $urandom, $urandom};
        e = (b == len - 1);
        send_a(d, b == 0, e, 4'($urandom_range(0, 15)));
      end
    end
    in_a.valid = 1'b0;
    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(negedge clk);
    check("random_drained", exp_q.size(), 0);
    rnd_rdy = 1'b0;
    idle_cycles(2);
    check("random_byte_count", out_bytes.size(), in_bytes.size());
    mism = 0;
    if (out_bytes.size() == in_bytes.size()) begin
      foreach (in_bytes[i]) if (in_bytes[i] !== out_bytes[i]) mism++;
    end
    check("random_byte_stream", mism, 0);

    // Reset while chunk 2 of a multi-beat packet is on the output.
    log_q.delete();
    send_a(128'hDEAD0000_DEAD0001_DEAD0002_DEAD0003, 1'b1, 1'b0, 4'd0);
    in_a.valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_reset_words", log_q.size(), 2);
    check("pre_reset_chunk2", {out_a.valid, out_a.data}, {1'b1, 32'hDEAD0002});
    rst = 1'b0;
    #1;
    check("mid_reset_valid", out_a.valid, 1'b0);
    check("mid_reset_in_rdy", in_a.rdy, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    idle_cycles(1);
    log_q.delete();
    send_a(128'h01020304_05060708_090A0B0C_0D0E0F10, 1'b1, 1'b1, 4'd2);
    in_a.valid = 1'b0;
    idle_cycles(6);
    check("post_reset_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check_word("post_reset_w0", 0, 32'h01020304, 1'b1, 1'b0, 2'd0);
      check_word("post_reset_w3", 3, 32'h0D0E0F10, 1'b0, 1'b1, 2'd2);
    end

    // 1:1 configuration: directed eop beat, then random pass-through.
    in_b.data = 64'h01234567_89ABCDEF; in_b.sop = 1'b1; in_b.eop = 1'b1; in_b.empty = 3'd5;
    in_b.valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 in_b.valid = 1'b0;
    @(negedge clk);
    check("b_direct", {out_b.valid, out_b.data, out_b.sop, out_b.eop, out_b.empty},
          {1'b1, 64'h01234567_89ABCDEF, 1'b1, 1'b1, 3'd5});
    @(posedge clk);
    #1;
    for (int k = 0; k < 40; k++) begin
      in_b.valid = ($urandom_range(0, 3) != 0);
      in_b.data  = {$urandom, $urandom};
      in_b.sop   = 1'($urandom_range(0, 1));
      in_b.eop   = 1'($urandom_range(0, 1));
      in_b.empty = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
    end
    in_b.valid = 1'b0;
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_st_downsizer.md
# avalon_st_downsizer

Parametrised Avalon-ST width adapter: accepts a wide packet stream of `IN_BYTES` bytes per beat and re-emits it as a narrow stream of `OUT_BYTES` bytes per beat, preserving `sop`/`eop` framing and recomputing `empty`. Sits between a wide datapath block (e.g. the enforcer) and a narrower consumer. Generalises the stream interface to two independent widths with full back-pressure support.

## Interface
- `IN_BYTES`, 16, input beat width in bytes.
- `OUT_BYTES`, 4, output beat width in bytes; `IN_BYTES % OUT_BYTES == 0` and `OUT_BYTES <= IN_BYTES`, else elaboration `$error`.
- `RATIO` (localparam) = `IN_BYTES/OUT_BYTES`; chunk counter width `log2up_func(RATIO)` from `general_pack`.

- `clk`  input  1  clock, all logic rising-edge.
- `rst`  input  1  asynchronous, active-low reset.
- `in_stream`  `avalon_st_if.slave`  `DATA_WIDTH_IN_BYTES=IN_BYTES`  wide input (data, valid, rdy, sop, eop, empty).
- `out_stream`  `avalon_st_if.master`  `DATA_WIDTH_IN_BYTES=OUT_BYTES`  narrow output.

## Operation
- Byte order: first byte of a beat is in the MSBs. Input beat splits into chunks 0..RATIO-1; chunk 0 = most significant `OUT_BYTES`.
- Holding register stores one accepted input beat plus sop, eop, and `last_idx`; `hold_valid` marks it occupied; `chunk_idx` selects the output chunk.
- States: IDLE (`hold_valid`=0), SEND (`hold_valid`=1).
- Load (IDLE, or SEND on the last-chunk handshake, with `in.valid && in.rdy`): capture beat, `chunk_idx`=0, `hold_valid`=1.
  - Non-eop beat: `last_idx`=RATIO-1; input `empty` ignored.
  - eop beat, empty=E: `V`=IN_BYTES-E; `last_idx`=ceil(V/OUT_BYTES)-1. Trailing chunks that would carry only empty bytes are never emitted.
- Output, combinational from the holding register:
  - `out.valid`=`hold_valid`; `out.data`=chunk[`chunk_idx`].
  - `out.sop`=held sop && `chunk_idx`==0.
  - `out.eop`=held eop && `chunk_idx`==`last_idx`.
  - `out.empty`=(`last_idx`+1)*OUT_BYTES-V on the eop chunk, else 0.
- Handshake: output beat transfers on `out.valid && out.rdy`.
  - Not last chunk: `chunk_idx`++.
  - Last chunk: load the next input beat if one is offered, else go to IDLE.
- `in.rdy` = !`hold_valid` || (`out.rdy` && `chunk_idx`==`last_idx`). Combinational from `out.rdy`; no extra bubble.
- Data, sop, eop and empty stay stable while `out.valid && !out.rdy`.
- RATIO=1: one-stage register; `out.empty`=input empty on eop.
- Framing errors (missing sop/eop) pass through unchanged; enforcement is upstream.

## Timing
- Reset (`rst`=0, async): `hold_valid`=0, `chunk_idx`=0, holding data, sop, eop and `last_idx` = 0.
  - Outputs: `out.valid`=0, `out.sop`=0, `out.eop`=0, `out.empty`=0, `out.data`=0.
  - `in.rdy`=1 combinationally once reset is asserted.
- Reset mid-packet discards the held beat and any remaining chunks. The first beat after reset must carry sop.
- Latency: an input beat accepted at edge N gives its first output chunk valid in cycle N+1.
- Throughput: with `out.rdy`=1, one output beat per cycle. A non-eop input beat is accepted every RATIO cycles with no gaps between chunks.
- Simultaneous last-chunk output handshake and input handshake in the same cycle: the next beat loads and `hold_valid` stays 1.
- `out.rdy`=0 on the last chunk: `in.rdy`=0 and the state holds.

## Test plan
- Single-beat packet, IN=16, OUT=4, sop=eop=1, empty=0, data=0x00112233_44556677_8899AABB_CCDDEEFF, `out.rdy`=1 -> 4 beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; sop on beat 0, eop on beat 3, empty=0; first beat at cycle +1.
- eop beat with empty=9 (V=7) -> 2 output beats; second has eop=1 and empty=1; chunks 2 and 3 are never emitted; `in.rdy`=1 in the cycle of the second beat.
- 3-beat packet streamed back-to-back with `out.rdy`=1 -> 12 consecutive output beats with no idle cycle; `in.rdy` pulses high once every 4 cycles.
- Random `out.rdy` (~50%) over 100 packets of random length and empty -> the output byte stream equals the input byte stream, and output data, sop, eop and empty never change while stalled.
- `rst` asserted during chunk 2 of a multi-beat packet -> `out.valid`=0 immediately and `in.rdy`=1; after release, a new sop packet is output correctly with no stale chunks.
- IN=OUT=8 (RATIO=1) -> 1:1 beat pass-through with 1-cycle latency; empty propagated unchanged on eop.
